// File: rtl/vram_hdma_ctrl.sv
// vram_hdma_ctrl: CGB general-purpose / H-blank DMA copying 16-byte blocks from the system bus into VRAM bank 0 or 1.
module vram_hdma_ctrl #(
  parameter int VRAM_AW     = 13,
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clk_ppu,
  input  logic        reset,
  input  logic [15:0] address_bus_offset,
  input  logic [7:0]  data_in,
  input  logic        mem_we,
  input  logic        VBK,
  input  logic [1:0]  STAT_mode,
  input  logic [7:0]  LCDC,
  input  logic [7:0]  data_in_dma_rd,
  output logic [15:0] address_bus_dma_rd,
  output logic        mem_enable_dma_rd,
  output logic [15:0] address_bus_dma_wr,
  output logic        mem_enable_dma_wr,
  output logic [7:0]  data_in_dma_wr,
  output logic        wr_en_VRAM_bank0_dma_wr,
  output logic        wr_en_VRAM_bank1_dma_wr,
  output logic [1:0]  dma_sel_VRAM_bank0,
  output logic [1:0]  dma_sel_VRAM_bank1,
  output logic        cpu_stall,
  output logic [7:0]  hdma_status
);
  localparam int BW = $clog2(BLOCK_BYTES);
  typedef enum logic [1:0] {IDLE, HWAIT, RD, WR} state_t;
  state_t               state_q;
  logic [15:0]          src_q;
  logic [VRAM_AW-1:0]   dst_q;
  logic [6:0]           blocks_q;
  logic [BW-1:0]        cnt_q;
  logic                 active_q, bank_q, hdma_q;
  logic [1:0]           mode_q;
  logic                 we51, we52, we53, we54, we55, hblank_rise, rd, wr, last;
  assign we51 = mem_we && address_bus_offset == 16'hFF51;
  assign we52 = mem_we && address_bus_offset == 16'hFF52;
  assign we53 = mem_we && address_bus_offset == 16'hFF53;
  assign we54 = mem_we && address_bus_offset == 16'hFF54;
  assign we55 = mem_we && address_bus_offset == 16'hFF55;
  assign hblank_rise = LCDC[7] && STAT_mode == 2'b00 && mode_q != 2'b00;
  assign rd = state_q == RD;
  assign wr = state_q == WR;
  assign last = cnt_q == BW'(BLOCK_BYTES - 1);
  always_ff @(posedge clk_ppu or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      blocks_q <= 7'h7F;
      cnt_q    <= '0;
      active_q <= 1'b0;
      bank_q   <= 1'b0;
      hdma_q   <= 1'b0;
      mode_q   <= 2'b00;
    end else begin
      mode_q <= STAT_mode;
      if (!active_q) begin
        if (we51) src_q[15:8] <= data_in;
        if (we52) src_q[7:0] <= {data_in[7:4], 4'h0};
        if (we53) dst_q[VRAM_AW-1:8] <= data_in[VRAM_AW-9:0];
        if (we54) dst_q[7:0] <= {data_in[7:4], 4'h0};
      end
      case (state_q)
        IDLE: if (we55) begin
          blocks_q <= data_in[6:0];
          bank_q   <= VBK;
          active_q <= 1'b1;
          hdma_q   <= data_in[7];
          state_q  <= data_in[7] ? HWAIT : RD;
        end
        HWAIT: if (we55 && data_in[7]) blocks_q <= data_in[6:0];
        else if (we55) begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end else if (hblank_rise) state_q <= RD;
        RD: state_q <= WR;
        WR: begin
          src_q <= src_q + 16'd1;
          dst_q <= dst_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (!last) state_q <= RD;
          else if (blocks_q == 7'd0) begin
            blocks_q <= 7'h7F;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            blocks_q <= blocks_q - 7'd1;
            state_q  <= hdma_q ? HWAIT : RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign address_bus_dma_rd      = src_q;
  assign mem_enable_dma_rd       = rd;
  assign address_bus_dma_wr      = {{(16-VRAM_AW){1'b0}}, dst_q};
  assign mem_enable_dma_wr       = wr;
  assign data_in_dma_wr          = wr ? data_in_dma_rd : 8'h00;
  assign wr_en_VRAM_bank0_dma_wr = wr && !bank_q;
  assign wr_en_VRAM_bank1_dma_wr = wr && bank_q;
  assign dma_sel_VRAM_bank0      = {wr && !bank_q, 1'b0};
  assign dma_sel_VRAM_bank1      = {wr && bank_q, 1'b0};
  assign cpu_stall               = rd || wr;
  assign hdma_status             = {~active_q, blocks_q};
endmodule

// File: tb/tb_vram_hdma_ctrl.sv
// tb_vram_hdma_ctrl: directed checks of GDMA, HDMA, cancel, ignored writes, wrap and mid-transfer reset.
module tb_vram_hdma_ctrl;
  logic        clk_ppu = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_bus_offset = '0;
  logic [7:0]  data_in = '0;
  logic        mem_we = 1'b0;
  logic        VBK = 1'b0;
  logic [1:0]  STAT_mode = 2'b10;
  logic [7:0]  LCDC = 8'h80;
  logic [7:0]  data_in_dma_rd = '0;
  logic [15:0] address_bus_dma_rd, address_bus_dma_wr;
  logic        mem_enable_dma_rd, mem_enable_dma_wr;
  logic [7:0]  data_in_dma_wr, hdma_status;
  logic        wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr, cpu_stall;
  logic [1:0]  dma_sel_VRAM_bank0, dma_sel_VRAM_bank1;
  logic [7:0]  vram0 [8192];
  logic [7:0]  vram1 [8192];
  int wr0_cnt = 0, wr1_cnt = 0, stall_cnt = 0;
  int vectors = 0, errs = 0;
  int b0, b1, bs;

  vram_hdma_ctrl dut (
    .clk_ppu(clk_ppu), .reset(reset), .address_bus_offset(address_bus_offset),
    .data_in(data_in), .mem_we(mem_we), .VBK(VBK), .STAT_mode(STAT_mode), .LCDC(LCDC),
    .data_in_dma_rd(data_in_dma_rd), .address_bus_dma_rd(address_bus_dma_rd),
    .mem_enable_dma_rd(mem_enable_dma_rd), .address_bus_dma_wr(address_bus_dma_wr),
    .mem_enable_dma_wr(mem_enable_dma_wr), .data_in_dma_wr(data_in_dma_wr),
    .wr_en_VRAM_bank0_dma_wr(wr_en_VRAM_bank0_dma_wr),
    .wr_en_VRAM_bank1_dma_wr(wr_en_VRAM_bank1_dma_wr),
    .dma_sel_VRAM_bank0(dma_sel_VRAM_bank0), .dma_sel_VRAM_bank1(dma_sel_VRAM_bank1),
    .cpu_stall(cpu_stall), .hdma_status(hdma_status)
  );

  always #5 clk_ppu = ~clk_ppu;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Source memory answers one cycle after the read enable; VRAM banks log writes.
  always @(posedge clk_ppu) begin
    if (mem_enable_dma_rd) data_in_dma_rd <= src_byte(address_bus_dma_rd);
    if (wr_en_VRAM_bank0_dma_wr) begin
      vram0[address_bus_dma_wr[12:0]] <= data_in_dma_wr;
      wr0_cnt <= wr0_cnt + 1;
    end
    if (wr_en_VRAM_bank1_dma_wr) begin
      vram1[address_bus_dma_wr[12:0]] <= data_in_dma_wr;
      wr1_cnt <= wr1_cnt + 1;
    end
    if (cpu_stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_ppu);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_ppu);
    address_bus_offset = a;
    data_in = d;
    mem_we = 1'b1;
    @(negedge clk_ppu);
    mem_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && cpu_stall; i++) @(negedge clk_ppu);
    chk("stall_timeout", {31'd0, cpu_stall}, 32'd0);
  endtask

  task automatic hblank();
    STAT_mode = 2'b11;
    cyc(2);
    STAT_mode = 2'b00;
    cyc(40);
    STAT_mode = 2'b10;
    cyc(2);
  endtask

  initial begin
    cyc(2);
    chk("rst_status", {24'd0, hdma_status}, 32'hFF);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_en", {28'd0, mem_enable_dma_rd, mem_enable_dma_wr, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr}, 32'd0);
    chk("rst_sel", {28'd0, dma_sel_VRAM_bank0, dma_sel_VRAM_bank1}, 32'd0);
    chk("rst_wdata", {24'd0, data_in_dma_wr}, 32'd0);
    reset = 1'b0;
    cyc(2);

    // GDMA: 2 blocks C000 -> bank0 offset 0
    cpu_wr(16'hFF51, 8'hC0);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h80);
    cpu_wr(16'hFF54, 8'h00);
    VBK = 1'b0;
    b0 = wr0_cnt; b1 = wr1_cnt; bs = stall_cnt;
    cpu_wr(16'hFF55, 8'h01);
    chk("gdma_stall_start", {31'd0, cpu_stall}, 32'd1);
    chk("gdma_rd_addr", {15'd0, mem_enable_dma_rd, address_bus_dma_rd}, {15'd0, 1'b1, 16'hC000});
    cyc(1);
    chk("gdma_wr_addr", {15'd0, mem_enable_dma_wr, address_bus_dma_wr}, {15'd0, 1'b1, 16'h0000});
    chk("gdma_sel", {28'd0, dma_sel_VRAM_bank0, dma_sel_VRAM_bank1}, {28'd0, 2'b10, 2'b00});
    chk("gdma_wdata", {24'd0, data_in_dma_wr}, {24'd0, src_byte(16'hC000)});
    wait_idle();
    cyc(1);
    chk("gdma_stall_cycles", stall_cnt - bs, 32'd64);
    chk("gdma_wr0", wr0_cnt - b0, 32'd32);
    chk("gdma_wr1", wr1_cnt - b1, 32'd0);
    chk("gdma_status", {24'd0, hdma_status}, 32'hFF);
    for (int i = 0; i < 32; i++)
      chk("gdma_data", {24'd0, vram0[i]}, {24'd0, src_byte(16'hC000 + 16'(i))});

    // HDMA: 3 blocks D010 -> bank1 offset 0120, with ignored register writes
    cpu_wr(16'hFF51, 8'hD0);
    cpu_wr(16'hFF52, 8'h10);
    cpu_wr(16'hFF53, 8'h01);
    cpu_wr(16'hFF54, 8'h20);
    VBK = 1'b1;
    b0 = wr0_cnt; b1 = wr1_cnt;
    cpu_wr(16'hFF55, 8'h82);
    VBK = 1'b0;
    chk("hdma_status0", {24'd0, hdma_status}, 32'h02);
    cyc(50);
    chk("hdma_no_early_wr", wr1_cnt - b1, 32'd0);
    chk("hdma_no_stall", {31'd0, cpu_stall}, 32'd0);
    hblank();
    chk("hdma_blk1_wr", wr1_cnt - b1, 32'd16);
    chk("hdma_status1", {24'd0, hdma_status}, 32'h01);
    cpu_wr(16'hFF51, 8'h12);
    cpu_wr(16'hFF53, 8'h1F);
    LCDC = 8'h00;
    hblank();
    chk("hdma_lcd_off", wr1_cnt - b1, 32'd16);
    LCDC = 8'h80;
    hblank();
    chk("hdma_blk2_wr", wr1_cnt - b1, 32'd32);
    chk("hdma_status2", {24'd0, hdma_status}, 32'h00);
    hblank();
    chk("hdma_blk3_wr", wr1_cnt - b1, 32'd48);
    chk("hdma_status3", {24'd0, hdma_status}, 32'hFF);
    chk("hdma_wr0", wr0_cnt - b0, 32'd0);
    for (int i = 0; i < 48; i++)
      chk("hdma_data", {24'd0, vram1[13'h0120 + 13'(i)]}, {24'd0, src_byte(16'hD010 + 16'(i))});

    // Cancel after 2 of 6 blocks
    cpu_wr(16'hFF51, 8'hE0);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h04);
    cpu_wr(16'hFF54, 8'h00);
    b0 = wr0_cnt;
    cpu_wr(16'hFF55, 8'h85);
    hblank();
    hblank();
    chk("cancel_pre_wr", wr0_cnt - b0, 32'd32);
    cpu_wr(16'hFF55, 8'h00);
    chk("cancel_status", {24'd0, hdma_status}, 32'h83);
    hblank();
    chk("cancel_no_wr", wr0_cnt - b0, 32'd32);
    chk("cancel_stall", {31'd0, cpu_stall}, 32'd0);

    // Source and destination wrap
    cpu_wr(16'hFF51, 8'hFF);
    cpu_wr(16'hFF52, 8'hF0);
    cpu_wr(16'hFF53, 8'h1F);
    cpu_wr(16'hFF54, 8'hF0);
    b0 = wr0_cnt;
    cpu_wr(16'hFF55, 8'h01);
    wait_idle();
    cyc(1);
    chk("wrap_wr0", wr0_cnt - b0, 32'd32);
    for (int i = 0; i < 32; i++) begin
      logic [12:0] d;
      logic [15:0] s;
      d = 13'h1FF0 + 13'(i);
      s = 16'hFFF0 + 16'(i);
      chk("wrap_data", {24'd0, vram0[d]}, {24'd0, src_byte(s)});
    end

    // Reset at byte 5 of a GDMA
    cpu_wr(16'hFF51, 8'hC0);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h08);
    cpu_wr(16'hFF54, 8'h00);
    b0 = wr0_cnt;
    cpu_wr(16'hFF55, 8'h00);
    cyc(10);
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'd0, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr, mem_enable_dma_wr}, 32'd0);
    chk("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mid_status", {24'd0, hdma_status}, 32'hFF);
    chk("rst_mid_wr_count", wr0_cnt - b0, 32'd5);
    cyc(2);
    reset = 1'b0;
    cyc(40);
    chk("rst_no_more_wr", wr0_cnt - b0, 32'd5);
    chk("rst_post_status", {24'd0, hdma_status}, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/vram_hdma_ctrl.md
Name: vram_hdma_ctrl

Overview:
- CGB general-purpose and H-blank DMA engine. Copies 16-byte blocks from the system bus into VRAM bank 0 or bank 1.
- Acts as the initiator on the PPU's DMA write port. It drives the dma_wr address, enable, data and write-enable, plus dma_sel_VRAM_bank0/1.
- Sources data through the dma_rd bus and stalls the CPU while a block is in flight.
- Registers FF51–FF55 are decoded here from the CPU bus.

Parameters:
- VRAM_AW, 13, VRAM byte address width; destination wraps modulo 2^VRAM_AW.
- BLOCK_BYTES, 16, bytes per block (power of two).

Ports:
- clk_ppu  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_bus_offset  in  16  CPU address.
- data_in  in  8  CPU write data.
- mem_we  in  1  CPU write strobe.
- VBK  in  1  VRAM bank select latched at transfer start (0 = bank0, 1 = bank1).
- STAT_mode  in  2  PPU mode.
- LCDC  in  8  bit 7 = LCD enable.
- data_in_dma_rd  in  8  source read data, valid the cycle after mem_enable_dma_rd.
- address_bus_dma_rd  out  16  source address.
- mem_enable_dma_rd  out  1  source read enable.
- address_bus_dma_wr  out  16  VRAM offset {3'b0, dst}.
- mem_enable_dma_wr  out  1  VRAM write-port enable.
- data_in_dma_wr  out  8  VRAM write data.
- wr_en_VRAM_bank0_dma_wr  out  1  write strobe to bank 0.
- wr_en_VRAM_bank1_dma_wr  out  1  write strobe to bank 1.
- dma_sel_VRAM_bank0  out  2  2'b10 while writing bank 0, else 2'b00.
- dma_sel_VRAM_bank1  out  2  2'b10 while writing bank 1, else 2'b00.
- cpu_stall  out  1  high while state is RD or WR.
- hdma_status  out  8  FF55 read value.

Behaviour:
- Reset values:
  - State IDLE; src = 0, dst = 0, blocks_left = 7'h7F, byte_cnt = 0, active = 0, bank = 0.
  - All enables and strobes 0; dma_sel 2'b00; data_in_dma_wr 0; cpu_stall 0.
  - hdma_status reads 8'hFF.
  - Reset mid-transfer aborts immediately; no further writes occur.
- Register writes (mem_we, address decode), accepted only when active = 0:
  - FF51 → src[15:8].
  - FF52 → src[7:4]; src[3:0] forced 0.
  - FF53 → dst[12:8] from data bits [4:0].
  - FF54 → dst[7:4]; dst[3:0] forced 0.
- FF55 write when idle:
  - blocks_left <= data[6:0]; bank <= VBK; active <= 1.
  - data[7] = 0 (GDMA): next state RD.
  - data[7] = 1 (HDMA): next state HWAIT.
- FF55 write while active, in HWAIT:
  - data[7] = 0 cancels: state IDLE, active = 0, blocks_left holds.
  - data[7] = 1 reloads blocks_left and stays in HWAIT.
- FF51–FF54 writes while active are ignored.
- hdma_status = {~active, blocks_left}. Reads FF after completion or reset. After a cancel, reads {1, blocks remaining minus 1}.
- States:
  - IDLE.
  - HWAIT: H-blank wait.
  - RD: mem_enable_dma_rd = 1, address_bus_dma_rd = src.
  - WR:
    - mem_enable_dma_wr = 1, address_bus_dma_wr = dst.
    - Selected bank's strobe = 1; data_in_dma_wr = data_in_dma_rd.
    - src++, dst++ (mod 2^VRAM_AW), byte_cnt++.
- Transitions:
  - RD → WR always.
  - WR → RD while byte_cnt != BLOCK_BYTES-1.
  - At end of block: if blocks_left == 0, blocks_left becomes 7'h7F, active = 0, state IDLE. Otherwise blocks_left decrements; GDMA → RD, HDMA → HWAIT.
- Timing:
  - 2 cycles per byte; 32 cycles per block.
  - GDMA of N+1 blocks: cpu_stall high for exactly 32·(N+1) cycles, starting the cycle after the FF55 write.
- H-blank trigger:
  - hblank_rise = LCDC[7] && STAT_mode == 00 && prev_mode != 00, where prev_mode is registered every cycle.
  - HWAIT → RD on hblank_rise. Exactly one block per H-blank.
  - With LCD off, HWAIT waits indefinitely.
- dma_sel of the selected bank = 2'b10 in WR only. The other bank stays 2'b00. dma_rd never selects VRAM.
- src wraps FFFF → 0000. dst wraps 1FFF → 0000.

Test Plan:
- GDMA: FF51=C0, FF52=00, FF53=80, FF54=00, VBK=0, FF55=01 → 32 bank-0 writes. Offsets 0x0000–0x001F carry source bytes C000–C01F in order. cpu_stall high exactly 64 cycles. hdma_status = FF afterwards.
- HDMA: FF55=82, VBK=1 → one 16-byte bank-1 burst per STAT_mode falling edge into 00. hdma_status = 02→01→00→FF across 3 H-blanks. No writes outside H-blank.
- Cancel: HDMA FF55=85, wait 2 H-blanks, write FF55=00 in HWAIT → state IDLE, no further writes. hdma_status = 0x83.
- Ignored writes: during active HDMA write FF51=12, FF53=1F → next block continues from the previous src/dst.
- Wrap: FF53=1F, FF54=F0, FF55=01 → dst offsets 1FF0–1FFF then 0000–000F.
- Reset: assert reset at byte 5 of a GDMA → all strobes 0 immediately, cpu_stall 0, hdma_status FF. No writes after release.
